// File: rtl/program_loader_if.sv
// Byte-stream handshake that carries a program image into the loader.
// The master drives bytes; the slave reports whether it can take one this cycle.
interface program_loader_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/program_loader.sv
// Writable 16x8 instruction store feeding the CPU fetch path; gates cpu_run until a full image is loaded.
// Optional trailing checksum byte verification is enabled with the LOADER_CHECKSUM_EN macro.
module program_loader #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    program_loader_if.slave   bus,
    input  logic              load_req,
    input  logic [AW-1:0]     pc,
    output logic [DW-1:0]     instr,
    output logic              cpu_run,
    output logic [AW:0]       load_cnt,
    output logic              err
);
    localparam int DEPTH = 1 << AW;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_CHK  = 2'd2,
        ST_FAIL = 2'd3
    } state_t;
`else
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
`endif

    state_t            state_reg;
    state_t            state_next;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW:0]       cnt_reg;
    logic              cpu_run_reg;
    logic [DW-1:0]     mem_reg [DEPTH];
    logic              in_ready;
    logic              xfer;
    logic              wr_en;
    logic              last_word;

`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0]     sum_reg;
    logic              err_reg;
`endif

    assign last_word = (wr_ptr_reg == AW'(DEPTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a reload request overrides everything else
    always_comb begin
        state_next = state_reg;
        if (load_req) begin
            state_next = ST_LOAD;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (xfer && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = ST_CHK;
`else
                        state_next = ST_RUN;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (xfer) begin
                        state_next = ((sum_reg + bus.in_data) == '0) ? ST_RUN : ST_FAIL;
                    end
                end
`endif
                default: state_next = state_reg;
            endcase
        end
    end

    // Output/handshake decode
    always_comb begin
        in_ready = 1'b0;
        if (!load_req) begin
`ifdef LOADER_CHECKSUM_EN
            in_ready = (state_reg == ST_LOAD) || (state_reg == ST_CHK);
`else
            in_ready = (state_reg == ST_LOAD);
`endif
        end
        xfer  = bus.in_valid && in_ready;
        wr_en = xfer && (state_reg == ST_LOAD);
    end

    assign bus.in_ready = in_ready;

    // Load pointer, byte count and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            cnt_reg     <= '0;
            cpu_run_reg <= 1'b0;
        end else begin
            cpu_run_reg <= (state_next == ST_RUN);
            if (load_req) begin
                wr_ptr_reg <= '0;
                cnt_reg    <= '0;
            end else if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                cnt_reg    <= cnt_reg + 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum covers only program bytes; the check byte is never accumulated
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            err_reg <= (state_next == ST_FAIL);
            if (load_req) begin
                sum_reg <= '0;
            end else if (wr_en) begin
                sum_reg <= sum_reg + bus.in_data;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // Store words are cleared on reset, so they live in fabric registers
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (!rst) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= bus.in_data;
                end
            end
        end
    endgenerate

    assign instr    = mem_reg[pc];
    assign cpu_run  = cpu_run_reg;
    assign load_cnt = cnt_reg;
endmodule
